// File: rtl/rv32f_seq_ctrl.sv
// Sequencing controller for an RV32F floating-point unit: issues one op at a time,
// times fixed-latency execution, arbitrates the RAM port for FLW/FSW and pulses writeback.
module rv32f_seq_ctrl (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [31:0] iIR,
    input  logic        iISSUE_VALID,
    output logic        oISSUE_READY,
    input  logic        iFLUSH,
    output logic [31:0] oIR,
    output logic [4:0]  oRD,
    output logic        oFPU_EN,
    output logic        oMEM_REQ,
    input  logic        iMEM_GNT,
    output logic        oWB_FP,
    output logic        oWB_INT,
    output logic        oILLEGAL,
    output logic        oBUSY
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_EXEC     = 3'd1;
    localparam logic [2:0] S_MEM_REQ  = 3'd2;
    localparam logic [2:0] S_MEM_DATA = 3'd3;
    localparam logic [2:0] S_WB       = 3'd4;

    localparam logic [6:0] OPC_FMADD  = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
    localparam logic [6:0] OPC_FLW    = 7'b0000111;
    localparam logic [6:0] OPC_FSW    = 7'b0100111;

    logic [2:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_ir;
    logic        r_wb_int;
    logic        r_is_store;
    logic        r_illegal;

    logic [2:0]  w_state_next;
    logic [3:0]  w_cnt_next;
    logic [6:0]  w_opcode;
    logic [6:0]  w_funct7;
    logic [3:0]  w_lat_m1;
    logic        w_is_exec;
    logic        w_is_mem;
    logic        w_is_store;
    logic        w_is_int;
    logic        w_illegal;
    logic        w_accept;

    assign w_opcode = iIR[6:0];
    assign w_funct7 = iIR[31:25];

    // Decode of the offered instruction; only consulted on the accept edge.
    always_comb begin
        w_lat_m1   = 4'd0;
        w_is_exec  = 1'b0;
        w_is_mem   = 1'b0;
        w_is_store = 1'b0;
        w_is_int   = 1'b0;
        case (w_opcode)
            OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
                w_is_exec = 1'b1;
                w_lat_m1  = 4'd3;
            end
            OPC_OP_FP: begin
                case (w_funct7)
                    7'b0000000, 7'b0000100, 7'b0001000: begin
                        w_is_exec = 1'b1;
                        w_lat_m1  = 4'd2;
                    end
                    7'b0001100, 7'b0101100: begin
                        w_is_exec = 1'b1;
                        w_lat_m1  = 4'd11;
                    end
                    7'b0010000, 7'b0010100, 7'b1101000, 7'b1111000: begin
                        w_is_exec = 1'b1;
                        w_lat_m1  = 4'd0;
                    end
                    // Compares, FCVT.W and FMV.X/FCLASS produce integer results.
                    7'b1010000, 7'b1100000, 7'b1110000: begin
                        w_is_exec = 1'b1;
                        w_lat_m1  = 4'd0;
                        w_is_int  = 1'b1;
                    end
                    default: w_is_exec = 1'b0;
                endcase
            end
            OPC_FLW: w_is_mem = 1'b1;
            OPC_FSW: begin
                w_is_mem   = 1'b1;
                w_is_store = 1'b1;
            end
            default: w_is_exec = 1'b0;
        endcase
    end

    assign w_illegal = !w_is_exec && !w_is_mem;
    assign w_accept  = iISSUE_VALID && oISSUE_READY && !iFLUSH;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (iFLUSH) begin
            w_state_next = S_IDLE;
            w_cnt_next   = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_exec) begin
                        w_state_next = S_EXEC;
                        w_cnt_next   = w_lat_m1;
                    end else if (w_accept && w_is_mem) begin
                        w_state_next = S_MEM_REQ;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == 4'd0) begin
                        w_state_next = S_WB;
                    end else begin
                        w_cnt_next = r_cnt - 4'd1;
                    end
                end
                S_MEM_REQ: begin
                    if (iMEM_GNT) begin
                        w_state_next = r_is_store ? S_IDLE : S_MEM_DATA;
                    end
                end
                S_MEM_DATA: w_state_next = S_WB;
                S_WB:       w_state_next = S_IDLE;
                default: begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_ir       <= 32'd0;
            r_wb_int   <= 1'b0;
            r_is_store <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_illegal <= w_accept && w_illegal;
            if (w_accept) begin
                r_ir       <= iIR;
                r_wb_int   <= w_is_int;
                r_is_store <= w_is_store;
            end
        end
    end

    // Ready is gated by reset directly so it drops the instant reset rises.
    assign oISSUE_READY = (r_state == S_IDLE) && !iRST;
    assign oIR          = r_ir;
    assign oRD          = r_ir[11:7];
    assign oFPU_EN      = (r_state == S_EXEC);
    assign oMEM_REQ     = (r_state == S_MEM_REQ);
    assign oWB_FP       = (r_state == S_WB) && !r_wb_int;
    assign oWB_INT      = (r_state == S_WB) && r_wb_int;
    assign oILLEGAL     = r_illegal;
    assign oBUSY        = (r_state != S_IDLE);

endmodule

// File: tb/tb_rv32f_seq_ctrl.sv
// Directed, table-driven bench for rv32f_seq_ctrl: one vector per clock cycle,
// plus hand-written latency and grant-hold sequences.
module tb_rv32f_seq_ctrl;

    logic        iCLK;
    logic        iRST;
    logic [31:0] iIR;
    logic        iISSUE_VALID;
    logic        oISSUE_READY;
    logic        iFLUSH;
    logic [31:0] oIR;
    logic [4:0]  oRD;
    logic        oFPU_EN;
    logic        oMEM_REQ;
    logic        iMEM_GNT;
    logic        oWB_FP;
    logic        oWB_INT;
    logic        oILLEGAL;
    logic        oBUSY;

    rv32f_seq_ctrl dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iIR          (iIR),
        .iISSUE_VALID (iISSUE_VALID),
        .oISSUE_READY (oISSUE_READY),
        .iFLUSH       (iFLUSH),
        .oIR          (oIR),
        .oRD          (oRD),
        .oFPU_EN      (oFPU_EN),
        .oMEM_REQ     (oMEM_REQ),
        .iMEM_GNT     (iMEM_GNT),
        .oWB_FP       (oWB_FP),
        .oWB_INT      (oWB_INT),
        .oILLEGAL     (oILLEGAL),
        .oBUSY        (oBUSY)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Expected flag vector: {ready, fpu_en, mem_req, wb_fp, wb_int, illegal, busy}
    localparam logic [6:0] F_RST   = 7'b0000000;
    localparam logic [6:0] F_IDLE  = 7'b1000000;
    localparam logic [6:0] F_EXEC  = 7'b0100001;
    localparam logic [6:0] F_MREQ  = 7'b0010001;
    localparam logic [6:0] F_MDATA = 7'b0000001;
    localparam logic [6:0] F_WBF   = 7'b0001001;
    localparam logic [6:0] F_WBI   = 7'b0000101;
    localparam logic [6:0] F_ILL   = 7'b1000010;

    localparam logic [31:0] I_FADD   = 32'h002081D3;
    localparam logic [31:0] I_FDIV   = 32'h182081D3;
    localparam logic [31:0] I_FLW    = 32'h0000A287;
    localparam logic [31:0] I_FEQ    = 32'hA020A553;
    localparam logic [31:0] I_FSW    = 32'h0020A027;
    localparam logic [31:0] I_ADDI   = 32'h00000013;
    localparam logic [31:0] I_FMADD  = 32'h10208243;
    localparam logic [31:0] I_FCVTW  = 32'hC0008553;
    localparam logic [31:0] I_BADFP  = 32'h020081D3;
    localparam logic [31:0] I_FSGNJ  = 32'h202081D3;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [31:0] ir;
        logic        flush;
        logic        gnt;
        logic [6:0]  flags;
        logic [4:0]  rd;
        logic [31:0] exp_ir;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] model_ir;
    int          n_vec;
    int          n_bad;

    // The expected oIR is the last instruction the table itself says was accepted.
    task automatic add(input logic rst, input logic valid, input logic [31:0] ir,
                       input logic flush, input logic gnt, input logic [6:0] flags);
        vec_t v;
        if (rst) model_ir = 32'd0;
        v.rst    = rst;
        v.valid  = valid;
        v.ir     = ir;
        v.flush  = flush;
        v.gnt    = gnt;
        v.flags  = flags;
        v.exp_ir = model_ir;
        v.rd     = model_ir[11:7];
        vecs.push_back(v);
        if (!rst && valid && !flush && flags[6]) model_ir = ir;
    endtask

    task automatic add_n(input int n, input logic [6:0] flags);
        for (int k = 0; k < n; k++) add(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, flags);
    endtask

    task automatic issue(input logic [31:0] ir);
        add(1'b0, 1'b1, ir, 1'b0, 1'b0, F_IDLE);
    endtask

    task automatic build_table;
        model_ir = 32'd0;
        add(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, F_RST);
        add(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, F_RST);
        // FADD: EXEC 1-3, WB_FP at 4, ready at 5
        issue(I_FADD); add_n(3, F_EXEC); add_n(1, F_WBF); add_n(1, F_IDLE);
        // FDIV: EXEC 1-12, WB_FP at 13
        issue(I_FDIV); add_n(12, F_EXEC); add_n(1, F_WBF); add_n(1, F_IDLE);
        // FLW with grant withheld for three cycles
        issue(I_FLW);
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, F_MREQ);
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, F_MREQ);
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, F_MREQ);
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, F_MREQ);
        add_n(1, F_MDATA); add_n(1, F_WBF); add_n(1, F_IDLE);
        // FEQ: integer writeback at cycle 2
        issue(I_FEQ); add_n(1, F_EXEC); add_n(1, F_WBI); add_n(1, F_IDLE);
        // FSW granted immediately: no writeback
        issue(I_FSW);
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, F_MREQ);
        add_n(2, F_IDLE);
        // Illegal opcode, then FADD back-to-back in the pulse cycle
        issue(I_ADDI);
        add(1'b0, 1'b1, I_FADD, 1'b0, 1'b0, F_ILL);
        add_n(3, F_EXEC); add_n(1, F_WBF); add_n(1, F_IDLE);
        // FDIV flushed in cycle 5
        issue(I_FDIV); add_n(4, F_EXEC);
        add(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, F_EXEC);
        add_n(3, F_IDLE);
        // Flush wins over a simultaneous issue
        add(1'b0, 1'b1, I_FADD, 1'b1, 1'b0, F_IDLE);
        add_n(2, F_IDLE);
        // FLW flushed while requesting, even with grant present
        issue(I_FLW);
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, F_MREQ);
        add(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, F_MREQ);
        add_n(2, F_IDLE);
        // FMADD: 4-cycle fused op, FP writeback despite funct7 field
        issue(I_FMADD); add_n(4, F_EXEC); add_n(1, F_WBF); add_n(1, F_IDLE);
        // FCVT.W.S: integer writeback
        issue(I_FCVTW); add_n(1, F_EXEC); add_n(1, F_WBI); add_n(1, F_IDLE);
        // OP-FP with unsupported funct7
        issue(I_BADFP); add_n(1, F_ILL); add_n(1, F_IDLE);
        // Reset in the middle of EXEC
        issue(I_FDIV); add_n(2, F_EXEC);
        add(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, F_RST);
        add_n(4, F_IDLE);
    endtask

    task automatic run_table;
        logic [6:0] got;
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge iCLK);
            #1;
            iRST         = vecs[i].rst;
            iISSUE_VALID = vecs[i].valid;
            iIR          = vecs[i].ir;
            iFLUSH       = vecs[i].flush;
            iMEM_GNT     = vecs[i].gnt;
            #3;
            got = {oISSUE_READY, oFPU_EN, oMEM_REQ, oWB_FP, oWB_INT, oILLEGAL, oBUSY};
            n_vec++;
            if (got !== vecs[i].flags || oRD !== vecs[i].rd || oIR !== vecs[i].exp_ir) begin
                n_bad++;
                $display("FAIL vec%0d: got flags=%07b rd=%0d ir=%08h, want flags=%07b rd=%0d ir=%08h",
                         i, got, oRD, oIR, vecs[i].flags, vecs[i].rd, vecs[i].exp_ir);
            end else begin
                $display("vec%0d: rst=%0b valid=%0b ir=%08h flush=%0b gnt=%0b -> flags=%07b rd=%0d",
                         i, vecs[i].rst, vecs[i].valid, vecs[i].ir, vecs[i].flush,
                         vecs[i].gnt, got, oRD);
            end
        end
    endtask

    // Issue-to-writeback distance in cycles, bounded so a stuck FSM still ends.
    task automatic latency(input string name, input logic [31:0] ir, input int expected);
        int lat;
        @(posedge iCLK);
        #1;
        iISSUE_VALID = 1'b1;
        iIR          = ir;
        @(posedge iCLK);
        #1;
        iISSUE_VALID = 1'b0;
        lat = 1;
        while (!(oWB_FP || oWB_INT) && lat < 40) begin
            @(posedge iCLK);
            #1;
            lat++;
        end
        n_vec++;
        if (lat != expected) begin
            n_bad++;
            $display("FAIL latency_%s: got %0d cycles, want %0d", name, lat, expected);
        end else begin
            $display("latency_%s: %0d cycles", name, lat);
        end
    endtask

    task automatic grant_hold;
        logic hold_ok;
        @(posedge iCLK);
        #1;
        iISSUE_VALID = 1'b1;
        iIR          = I_FLW;
        iMEM_GNT     = 1'b0;
        @(posedge iCLK);
        #1;
        iISSUE_VALID = 1'b0;
        hold_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (oMEM_REQ !== 1'b1 || oWB_FP !== 1'b0) hold_ok = 1'b0;
            @(posedge iCLK);
            #1;
        end
        iMEM_GNT = 1'b1;
        if (oMEM_REQ !== 1'b1) hold_ok = 1'b0;
        n_vec++;
        if (!hold_ok) begin
            n_bad++;
            $display("FAIL mem_hold: oMEM_REQ dropped or early writeback during 21 ungranted cycles, want held");
        end else begin
            $display("mem_hold: oMEM_REQ held 21 cycles");
        end
        @(posedge iCLK);
        #1;
        iMEM_GNT = 1'b0;
        @(posedge iCLK);
        #1;
        n_vec++;
        if (oWB_FP !== 1'b1 || oRD !== 5'd5 || oMEM_REQ !== 1'b0) begin
            n_bad++;
            $display("FAIL mem_wb: got wb_fp=%0b rd=%0d mem_req=%0b, want wb_fp=1 rd=5 mem_req=0",
                     oWB_FP, oRD, oMEM_REQ);
        end else begin
            $display("mem_wb: wb_fp=1 rd=5 two cycles after grant");
        end
    endtask

    initial begin
        iRST         = 1'b1;
        iIR          = 32'd0;
        iISSUE_VALID = 1'b0;
        iFLUSH       = 1'b0;
        iMEM_GNT     = 1'b0;
        n_vec        = 0;
        n_bad        = 0;
        build_table();
        run_table();
        latency("fdiv", I_FDIV, 13);
        latency("fmadd", I_FMADD, 5);
        latency("fsgnj", I_FSGNJ, 2);
        latency("fadd", I_FADD, 4);
        grant_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
